// File: rtl/freq_meas_scheduler.sv
// Gated edge-count frequency meter time-multiplexed over NUM_CH inputs.
// Channels are swept select -> settle -> gate -> calc -> report, once or round-robin.
module freq_meas_scheduler #(
    parameter int unsigned NUM_CH        = 4,
    parameter logic [63:0] CLK_FREQ_HZ   = 64'd50_000_000,
    parameter logic [63:0] GATE_CYCLES   = 64'd25_000_000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] sig_in,
    output logic              busy,
    output logic [31:0]       fre,
    output logic [2:0]        fre_ch,
    output logic              fre_valid,
    output logic              fre_ovf,
    output logic              done
);

    localparam logic [63:0] SCALE       = CLK_FREQ_HZ / GATE_CYCLES;
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 64'd1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_CALC,
        S_REPORT
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [2:0]          ch_q, ch_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [31:0]         edge_cnt_q, edge_cnt_d;
    logic                prev_q, prev_d;
    logic [NUM_CH-1:0]   sync1_q, sync1_d;
    logic [NUM_CH-1:0]   sync2_q, sync2_d;
    logic [31:0]         res_q, res_d;
    logic                res_ovf_q, res_ovf_d;
    logic                busy_q, busy_d;
    logic [31:0]         fre_q, fre_d;
    logic [2:0]          fre_ch_q, fre_ch_d;
    logic                fre_valid_q, fre_valid_d;
    logic                fre_ovf_q, fre_ovf_d;
    logic                done_q, done_d;

    logic                sel;
    logic [3:0]          first_en;
    logic [3:0]          next_en;
    logic [63:0]         product;

    // Lowest set bit of m at index >= from; bit 3 of the result flags "found".
    function automatic logic [3:0] find_from(input logic [NUM_CH-1:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        cyc_d       = cyc_q;
        edge_cnt_d  = edge_cnt_q;
        prev_d      = prev_q;
        res_d       = res_q;
        res_ovf_d   = res_ovf_q;
        busy_d      = busy_q;
        fre_d       = fre_q;
        fre_ch_d    = fre_ch_q;
        fre_ovf_d   = fre_ovf_q;
        fre_valid_d = 1'b0;
        done_d      = 1'b0;
        sync1_d     = sig_in;
        sync2_d     = sync1_q;

        sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 3'(i)) begin
                sel = sync2_q[i];
            end
        end

        first_en = find_from(ch_en, 4'd0);
        next_en  = find_from(mask_q, {1'b0, ch_q} + 4'd1);
        product  = 64'(edge_cnt_q) * SCALE;

        case (state_q)
            S_IDLE: begin
                cyc_d      = 32'd0;
                edge_cnt_d = 32'd0;
                busy_d     = 1'b0;
                if (start && !busy_q && (ch_en != '0)) begin
                    mask_d  = ch_en;
                    ch_d    = first_en[2:0];
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            // History tracks the new channel so the first gate cycle cannot see a false edge.
            S_SETTLE: begin
                edge_cnt_d = 32'd0;
                prev_d     = sel;
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = 32'd0;
                    state_d = S_GATE;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            S_GATE: begin
                prev_d = sel;
                if (sel && !prev_q && (edge_cnt_q != 32'hFFFF_FFFF)) begin
                    edge_cnt_d = edge_cnt_q + 32'd1;
                end
                if (cyc_q == GATE_LAST) begin
                    cyc_d   = 32'd0;
                    state_d = S_CALC;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            S_CALC: begin
                if (product[63:32] != 32'd0) begin
                    res_d     = 32'hFFFF_FFFF;
                    res_ovf_d = 1'b1;
                end else begin
                    res_d     = product[31:0];
                    res_ovf_d = 1'b0;
                end
                state_d = S_REPORT;
            end
            // Result registers update here; fre_valid/done are seen the following cycle.
            S_REPORT: begin
                fre_d       = res_q;
                fre_ch_d    = ch_q;
                fre_ovf_d   = res_ovf_q;
                fre_valid_d = 1'b1;
                cyc_d       = 32'd0;
                if (next_en[3]) begin
                    ch_d    = next_en[2:0];
                    state_d = S_SETTLE;
                end else if (cont) begin
                    mask_d = ch_en;
                    if (first_en[3]) begin
                        ch_d    = first_en[2:0];
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            ch_q        <= 3'd0;
            cyc_q       <= 32'd0;
            edge_cnt_q  <= 32'd0;
            prev_q      <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            res_q       <= 32'd0;
            res_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
            fre_q       <= 32'd0;
            fre_ch_q    <= 3'd0;
            fre_valid_q <= 1'b0;
            fre_ovf_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            cyc_q       <= cyc_d;
            edge_cnt_q  <= edge_cnt_d;
            prev_q      <= prev_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            res_q       <= res_d;
            res_ovf_q   <= res_ovf_d;
            busy_q      <= busy_d;
            fre_q       <= fre_d;
            fre_ch_q    <= fre_ch_d;
            fre_valid_q <= fre_valid_d;
            fre_ovf_q   <= fre_ovf_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign fre       = fre_q;
    assign fre_ch    = fre_ch_q;
    assign fre_valid = fre_valid_q;
    assign fre_ovf   = fre_ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Directed bench for freq_meas_scheduler: single/multi-channel sweeps, continuous mode,
// saturation, ignored starts and mid-gate reset.
module tb_freq_meas_scheduler;

    localparam int NCH = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        cont   = 1'b0;
    logic [3:0]  ch_en  = 4'd0;
    logic [3:0]  sig_in = 4'd0;
    logic        busy;
    logic [31:0] fre;
    logic [2:0]  fre_ch;
    logic        fre_valid;
    logic        fre_ovf;
    logic        done;

    logic        start2   = 1'b0;
    logic        sig_fast = 1'b0;
    logic        busy2;
    logic [31:0] fre2;
    logic [2:0]  fre_ch2;
    logic        fre_valid2;
    logic        fre_ovf2;
    logic        done2;

    int n_checks = 0;
    int n_errors = 0;
    int tick     = 0;
    int half_p [4] = '{0, 0, 0, 0};
    logic lvl  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    logic [31:0] q_fre  [$];
    int          q_ch   [$];
    logic        q_ovf  [$];
    logic        q_done [$];

    freq_meas_scheduler #(
        .NUM_CH(NCH),
        .CLK_FREQ_HZ(64'd1_000_000),
        .GATE_CYCLES(64'd1000),
        .SETTLE_CYCLES(16)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .start(start),
        .cont(cont),
        .ch_en(ch_en),
        .sig_in(sig_in),
        .busy(busy),
        .fre(fre),
        .fre_ch(fre_ch),
        .fre_valid(fre_valid),
        .fre_ovf(fre_ovf),
        .done(done)
    );

    // SCALE = 2^24 here, so 500 edges give 500 * 2^24 = 8_388_608_000 > 2^32 - 1.
    freq_meas_scheduler #(
        .NUM_CH(NCH),
        .CLK_FREQ_HZ(64'd16_777_216_000),
        .GATE_CYCLES(64'd1000),
        .SETTLE_CYCLES(16)
    ) dut_ovf (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .start(start2),
        .cont(1'b0),
        .ch_en(4'b0001),
        .sig_in({3'b000, sig_fast}),
        .busy(busy2),
        .fre(fre2),
        .fre_ch(fre_ch2),
        .fre_valid(fre_valid2),
        .fre_ovf(fre_ovf2),
        .done(done2)
    );

    initial forever #5 clk = ~clk;

    // Square waves with half-period half_p[c] cycles, or a static level when half_p[c] is 0.
    initial begin
        forever begin
            @(negedge clk);
            tick++;
            sig_fast = ~sig_fast;
            for (int c = 0; c < NCH; c++) begin
                sig_in[c] = (half_p[c] == 0) ? lvl[c] : (((tick / half_p[c]) % 2) == 1);
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic run_sweep(input int max_cyc, input int poke_at, input int cont_drop_at,
                             output int n_busy, output bit timed_out);
        q_fre.delete();
        q_ch.delete();
        q_ovf.delete();
        q_done.delete();
        n_busy    = 0;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            start = (i == poke_at);
            if (i == cont_drop_at) cont = 1'b0;
            if (busy) n_busy++;
            if (fre_valid) begin
                q_fre.push_back(fre);
                q_ch.push_back(int'(fre_ch));
                q_ovf.push_back(fre_ovf);
                q_done.push_back(done);
            end
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"},  64'(busy),      64'd0);
        check_val({tag, "_fre"},   64'(fre),       64'd0);
        check_val({tag, "_ch"},    64'(fre_ch),    64'd0);
        check_val({tag, "_valid"}, 64'(fre_valid), 64'd0);
        check_val({tag, "_ovf"},   64'(fre_ovf),   64'd0);
        check_val({tag, "_done"},  64'(done),      64'd0);
    endtask

    initial begin
        int  nb;
        bit  to;
        int  seen;
        bit  got2;

        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single channel, period 10 -> 100 edges * 1000 = 100_000.
        half_p[0] = 5;
        ch_en     = 4'b0001;
        cont      = 1'b0;
        run_sweep(1100, -1, -1, nb, to);
        check_val("t1_timeout", 64'(to), 64'd0);
        check_val("t1_nrep", 64'(q_fre.size()), 64'd1);
        if (q_fre.size() >= 1) begin
            check_val("t1_fre",  64'(q_fre[0]),  64'd100_000);
            check_val("t1_ch",   64'(q_ch[0]),   64'd0);
            check_val("t1_ovf",  64'(q_ovf[0]),  64'd0);
            check_val("t1_done", 64'(q_done[0]), 64'd1);
        end
        check_val("t1_busy_cycles", 64'(nb), 64'd1019);
        @(negedge clk);
        check_val("t1_busy_after", 64'(busy), 64'd0);

        // Channels 1 and 3 enabled; a second start mid-gate must be ignored.
        half_p[0] = 5;
        half_p[1] = 10;
        half_p[2] = 7;
        half_p[3] = 2;
        ch_en     = 4'b1010;
        run_sweep(2300, 500, -1, nb, to);
        check_val("t2_timeout", 64'(to), 64'd0);
        check_val("t2_nrep", 64'(q_fre.size()), 64'd2);
        if (q_fre.size() >= 2) begin
            check_val("t2_ch_a",   64'(q_ch[0]),   64'd1);
            check_val("t2_fre_a",  64'(q_fre[0]),  64'd50_000);
            check_val("t2_done_a", 64'(q_done[0]), 64'd0);
            check_val("t2_ch_b",   64'(q_ch[1]),   64'd3);
            check_val("t2_fre_b",  64'(q_fre[1]),  64'd250_000);
            check_val("t2_done_b", 64'(q_done[1]), 64'd1);
        end
        check_val("t2_busy_cycles", 64'(nb), 64'd2037);
        @(negedge clk);
        check_val("t2_busy_after", 64'(busy), 64'd0);

        // Reset for one cycle mid-gate discards the measurement in flight.
        half_p[0] = 5;
        ch_en     = 4'b0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("t6_rst");
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (fre_valid || busy) seen++;
        end
        check_val("t6_quiet", 64'(seen), 64'd0);
        run_sweep(1100, -1, -1, nb, to);
        check_val("t6_timeout", 64'(to), 64'd0);
        check_val("t6_nrep", 64'(q_fre.size()), 64'd1);
        if (q_fre.size() >= 1) begin
            check_val("t6_fre", 64'(q_fre[0]), 64'd100_000);
            check_val("t6_ch",  64'(q_ch[0]),  64'd0);
        end
        check_val("t6_busy_cycles", 64'(nb), 64'd1019);

        // Continuous mode on a channel stuck high; cont dropped during the third gate.
        half_p[0] = 0;
        lvl[0]    = 1'b1;
        ch_en     = 4'b0001;
        cont      = 1'b1;
        repeat (5) @(negedge clk);
        run_sweep(4000, -1, 2500, nb, to);
        check_val("t3_timeout", 64'(to), 64'd0);
        check_val("t3_nrep", 64'(q_fre.size()), 64'd3);
        for (int k = 0; k < q_fre.size(); k++) begin
            check_val($sformatf("t3_fre%0d", k), 64'(q_fre[k]), 64'd0);
            check_val($sformatf("t3_done%0d", k), 64'(q_done[k]), (k == 2) ? 64'd1 : 64'd0);
        end
        check_val("t3_busy_cycles", 64'(nb), 64'd3055);
        @(negedge clk);
        check_val("t3_busy_after", 64'(busy), 64'd0);

        // start with an empty mask does nothing.
        ch_en = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || fre_valid || done) seen++;
            @(negedge clk);
        end
        check_val("t4_idle", 64'(seen), 64'd0);

        // Saturation on the high-SCALE instance.
        @(negedge clk);
        start2 = 1'b1;
        got2   = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (fre_valid2) begin
                got2 = 1'b1;
                check_val("t5_fre",  64'(fre2),    64'hFFFF_FFFF);
                check_val("t5_ovf",  64'(fre_ovf2), 64'd1);
                check_val("t5_ch",   64'(fre_ch2),  64'd0);
                check_val("t5_done", 64'(done2),    64'd1);
                break;
            end
        end
        check_val("t5_report_seen", 64'(got2), 64'd1);
        @(negedge clk);
        check_val("t5_busy_after", 64'(busy2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
